crash_sched: RTL and testbench
==============================

# crash_sched

Game-state controller and collision scheduler for the plane-vs-enemy path. On each video frame tick it time-multiplexes one shared hit comparator across all enemy/projectile slots, one slot per cycle, using signed absolute-difference boxes. It owns the lives counter, post-hit grace window and game-over state, and drives the crash/restart signals consumed by the renderer and the enemy generators.

## Interface
- `N_OBJ`, 3, number of object slots scanned (enemy, projectile 1, projectile 2)
- `HIT_DX`, 70, max |obj_x − plane_x| counted as overlap (inclusive)
- `HIT_DY`, 90, max |obj_y − plane_y| counted as overlap (exclusive)
- `LIVES`, 3, lives loaded on game start (1..7)
- `GRACE_FRAMES`, 60, frame ticks of invulnerability after a non-fatal hit (≥1)
- `clk` in 1 system clock
- `rst_n` in 1 asynchronous active-low reset
- `start` in 1 start/restart button, active-low level, already debounced
- `frame_tick` in 1 one-cycle pulse per video frame
- `obj_x` in 12·N_OBJ packed slot X, slot k at [12k+11:12k]
- `obj_y` in 12·N_OBJ packed slot Y, same packing
- `obj_valid` in N_OBJ slot k alive; invalid slots never hit
- `plane_x`, `plane_y` in 12 each player plane position
- `state` out 2 00 IDLE, 01 PLAY, 10 GRACE, 11 OVER
- `lives` out 3 remaining lives
- `crash_pulse` out 1 one-cycle pulse per registered hit
- `hit_id` out 2 slot index of the last hit
- `scan_busy` out 1 scan in progress
- `game_over` out 1 high while in OVER

## Operation
- Reset: state IDLE, lives=LIVES, crash_pulse 0, hit_id 0, scan_busy 0, game_over 0, scan index 0.
- `start` falling edge (1→0, registered previous value, reset value 1) in IDLE or OVER: lives←LIVES, → PLAY. Ignored in PLAY/GRACE.
- Scan (PLAY only): frame_tick with scan_busy=0 latches plane_x/plane_y, sets index 0, scan_busy=1. Each following cycle evaluates slot `index` against latched plane: dx=obj_x−plane_x, dy=obj_y−plane_y in 13-bit signed; hit = obj_valid[index] && |dx| ≤ HIT_DX && |dy| < HIT_DY. Object positions are read live per cycle.
- First hit ends scan: crash_pulse=1 next cycle, hit_id←index, lives←lives−1. If lives was 1 → OVER (lives=0), else → GRACE with grace counter←GRACE_FRAMES. No hit after slot N_OBJ−1: scan_busy←0, stay PLAY.
- frame_tick while scan_busy=1: ignored (no restart, no queuing).
- GRACE: no scans; each frame_tick decrements counter; at 0 → PLAY. Next scan starts on the next frame_tick after entry.
- OVER: game_over=1, no scans; only start edge exits.
- Leaving PLAY clears scan_busy. At most one crash_pulse per frame.

## Timing
- frame_tick sampled high in cycle t → slot k evaluated in cycle t+1+k.
- Hit at slot k → crash_pulse, hit_id, lives, state all update in cycle t+2+k; crash_pulse lasts exactly one cycle.
- No hit: scan_busy high cycles t+1..t+N_OBJ, low at t+N_OBJ+1.
- Start edge at sample cycle s → state PLAY at s+1.
- GRACE entered at cycle g; the GRACE_FRAMES-th subsequent frame_tick at cycle f → PLAY at f+1.
- rst_n assertion mid-scan or mid-grace: immediate return to reset values, no pulse.

## Configuration
- `CRASH_GRACE_EN` defined: GRACE state and counter as above.
- Undefined: non-fatal hit returns directly to PLAY (state never 10); counter logic removed; next frame_tick starts a new scan.

## Test plan
- Reset, start low edge, plane (400,300), slot 1 valid at (460,350), others invalid, one frame_tick at cycle t → crash_pulse at t+3, hit_id=1, lives 3→2, state GRACE.
- Signed wrap: plane (10,300), slot 0 at (4090,300) valid → no hit (dx=4080 not |−16| aliasing); slot 0 at (0,300) → hit (|dx|=10).
- Boundaries: |dx|=70,|dy|=89 → hit; |dx|=71 → none; |dy|=90 → none.
- Three hits with GRACE_FRAMES=2 and tick stream → lives 2,1,0, state OVER, game_over=1; further ticks give no pulses; start edge → PLAY, lives=3.
- frame_tick repeated during busy scan with no hits → single scan, scan_busy low N_OBJ+1 cycles after first tick.
- rst_n low in GRACE with counter=1 → state IDLE, lives=3 asynchronously, no crash_pulse.

Source files
------------

// File: rtl/crash_sched_if.sv
// Bus between the crash scheduler and its neighbours: object/plane positions in,
// game status and crash strobe out.
interface crash_sched_if #(
    parameter int N_OBJ = 3
);
    logic                 start;
    logic                 frame_tick;
    logic [12*N_OBJ-1:0]  obj_x;
    logic [12*N_OBJ-1:0]  obj_y;
    logic [N_OBJ-1:0]     obj_valid;
    logic [11:0]          plane_x;
    logic [11:0]          plane_y;
    logic [1:0]           state;
    logic [2:0]           lives;
    logic                 crash_pulse;
    logic [1:0]           hit_id;
    logic                 scan_busy;
    logic                 game_over;

    modport master (
        output start, frame_tick, obj_x, obj_y, obj_valid, plane_x, plane_y,
        input  state, lives, crash_pulse, hit_id, scan_busy, game_over
    );

    modport slave (
        input  start, frame_tick, obj_x, obj_y, obj_valid, plane_x, plane_y,
        output state, lives, crash_pulse, hit_id, scan_busy, game_over
    );
endinterface

// File: rtl/crash_sched.sv
// Game-state controller and one-slot-per-cycle collision scheduler.
// CRASH_GRACE_EN enables the post-hit invulnerability window (GRACE state).
//
// state | meaning
// IDLE  | waiting for the first start press
// PLAY  | scanning slots on each frame tick
// GRACE | invulnerable, counting frame ticks down
// OVER  | no lives left, waiting for start
module crash_sched #(
    parameter int N_OBJ        = 3,
    parameter int HIT_DX       = 70,
    parameter int HIT_DY       = 90,
    parameter int LIVES        = 3,
    parameter int GRACE_FRAMES = 60
) (
    input  logic         clk,
    input  logic         rst_n,
    crash_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, GRACE = 2'b10, OVER = 2'b11} state_t;

    localparam logic [12:0] DX_MAX  = 13'(HIT_DX);
    localparam logic [12:0] DY_LIM  = 13'(HIT_DY);
    localparam logic [2:0]  LIVES_L = 3'(LIVES);
    localparam logic [1:0]  LAST    = 2'(N_OBJ - 1);

    state_t      state_q, state_nxt;
    logic [2:0]  lives_q, lives_nxt;
    logic        busy_q, busy_nxt;
    logic [1:0]  idx_q, idx_nxt;
    logic        pulse_q, pulse_nxt;
    logic [1:0]  hit_id_q, hit_id_nxt;
    logic [11:0] px_q, px_nxt, py_q, py_nxt;
    logic        start_q;
    logic        start_fall;

`ifdef CRASH_GRACE_EN
    localparam int CW = $clog2(GRACE_FRAMES + 1);
    logic [CW-1:0] cnt_q, cnt_nxt;
`endif

    logic [11:0]        ox, oy;
    logic               ov;
    logic signed [12:0] dx, dy;
    logic [12:0]        adx, ady;
    logic               hit;

    assign start_fall = start_q & ~bus.start;

    always_comb begin
        ox = '0;
        oy = '0;
        ov = 1'b0;
        for (int k = 0; k < N_OBJ; k++) begin
            if (idx_q == 2'(k)) begin
                ox = bus.obj_x[12*k +: 12];
                oy = bus.obj_y[12*k +: 12];
                ov = bus.obj_valid[k];
            end
        end
    end

    // Zero-extend before subtracting so 4090 vs 10 stays a large distance, not -16.
    assign dx  = $signed({1'b0, ox}) - $signed({1'b0, px_q});
    assign dy  = $signed({1'b0, oy}) - $signed({1'b0, py_q});
    assign adx = dx[12] ? 13'(-dx) : 13'(dx);
    assign ady = dy[12] ? 13'(-dy) : 13'(dy);
    assign hit = ov && (adx <= DX_MAX) && (ady < DY_LIM);

    always_comb begin
        state_nxt  = state_q;
        lives_nxt  = lives_q;
        busy_nxt   = busy_q;
        idx_nxt    = idx_q;
        pulse_nxt  = 1'b0;
        hit_id_nxt = hit_id_q;
        px_nxt     = px_q;
        py_nxt     = py_q;
`ifdef CRASH_GRACE_EN
        cnt_nxt    = cnt_q;
`endif
        case (state_q)
            IDLE, OVER: begin
                if (start_fall) begin
                    state_nxt = PLAY;
                    lives_nxt = LIVES_L;
                end
            end
            PLAY: begin
                if (busy_q) begin
                    if (hit) begin
                        pulse_nxt  = 1'b1;
                        hit_id_nxt = idx_q;
                        lives_nxt  = lives_q - 3'd1;
                        busy_nxt   = 1'b0;
                        idx_nxt    = '0;
                        if (lives_q == 3'd1) begin
                            state_nxt = OVER;
                        end else begin
`ifdef CRASH_GRACE_EN
                            state_nxt = GRACE;
                            cnt_nxt   = CW'(GRACE_FRAMES);
`endif
                        end
                    end else if (idx_q == LAST) begin
                        busy_nxt = 1'b0;
                        idx_nxt  = '0;
                    end else begin
                        idx_nxt = idx_q + 2'd1;
                    end
                end else if (bus.frame_tick) begin
                    busy_nxt = 1'b1;
                    idx_nxt  = '0;
                    px_nxt   = bus.plane_x;
                    py_nxt   = bus.plane_y;
                end
            end
`ifdef CRASH_GRACE_EN
            GRACE: begin
                if (bus.frame_tick) begin
                    cnt_nxt = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_nxt = PLAY;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lives_q  <= LIVES_L;
            busy_q   <= 1'b0;
            idx_q    <= '0;
            pulse_q  <= 1'b0;
            hit_id_q <= '0;
            px_q     <= '0;
            py_q     <= '0;
            start_q  <= 1'b1;
        end else begin
            state_q  <= state_nxt;
            lives_q  <= lives_nxt;
            busy_q   <= busy_nxt;
            idx_q    <= idx_nxt;
            pulse_q  <= pulse_nxt;
            hit_id_q <= hit_id_nxt;
            px_q     <= px_nxt;
            py_q     <= py_nxt;
            start_q  <= bus.start;
        end
    end

`ifdef CRASH_GRACE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_nxt;
    end
`endif

    assign bus.state       = state_q;
    assign bus.lives       = lives_q;
    assign bus.crash_pulse = pulse_q;
    assign bus.hit_id      = hit_id_q;
    assign bus.scan_busy   = busy_q;
    assign bus.game_over   = (state_q == OVER);
endmodule

// File: tb/tb_crash_sched.sv
// Self-checking bench for crash_sched: directed scenarios plus random frames
// checked against a frame-level game model.
module tb_crash_sched;
    localparam int N   = 3;
    localparam int HDX = 70;
    localparam int HDY = 90;
    localparam int LV  = 3;
    localparam int GF  = 2;
    localparam int S_IDLE = 0, S_PLAY = 1, S_GRACE = 2, S_OVER = 3;

    logic clk;
    logic rst_n;
    crash_sched_if #(.N_OBJ(N)) bus ();

    crash_sched #(.N_OBJ(N), .HIT_DX(HDX), .HIT_DY(HDY), .LIVES(LV), .GRACE_FRAMES(GF)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int m_state, m_lives, m_hit, m_cnt;
    int ox[N], oy[N];
    bit ov[N];
    int px, py;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_lives = LV;
        m_hit   = 0;
        m_cnt   = 0;
    endtask

    task automatic check_status(input string tag);
        chk({tag, ".state"}, int'(bus.state), m_state);
        chk({tag, ".lives"}, int'(bus.lives), m_lives);
        chk({tag, ".hit_id"}, int'(bus.hit_id), m_hit);
        chk({tag, ".game_over"}, int'(bus.game_over), int'(m_state == S_OVER));
    endtask

    task automatic drive_bus();
        for (int k = 0; k < N; k++) begin
            bus.obj_x[12*k +: 12] = 12'(ox[k]);
            bus.obj_y[12*k +: 12] = 12'(oy[k]);
            bus.obj_valid[k]      = ov[k];
        end
        bus.plane_x = 12'(px);
        bus.plane_y = 12'(py);
    endtask

    task automatic set_obj(input int k, input int x, input int y, input bit v);
        ox[k] = x;
        oy[k] = y;
        ov[k] = v;
    endtask

    task automatic clear_objs();
        for (int k = 0; k < N; k++) set_obj(k, 0, 0, 1'b0);
    endtask

    function automatic int first_hit();
        int ddx, ddy;
        for (int k = 0; k < N; k++) begin
            ddx = ox[k] - px;
            ddy = oy[k] - py;
            if (ddx < 0) ddx = -ddx;
            if (ddy < 0) ddy = -ddy;
            if (ov[k] && ddx <= HDX && ddy < HDY) return k;
        end
        return -1;
    endfunction

    // One frame tick, then watch the scan window cycle by cycle.
    task automatic do_frame(input string tag);
        int h, got_cyc, npulse, exp_cyc;
        bit was_play;
        drive_bus();
        was_play = (m_state == S_PLAY);
        h = was_play ? first_hit() : -1;
        bus.frame_tick = 1'b1;
        got_cyc = 0;
        npulse  = 0;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        chk({tag, ".busy_start"}, int'(bus.scan_busy), int'(was_play));
        for (int c = 1; c <= N + 1; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.crash_pulse) begin
                npulse++;
                if (got_cyc == 0) got_cyc = c;
            end
        end
        exp_cyc = (h >= 0) ? h + 2 : 0;
        chk({tag, ".pulse_cyc"}, got_cyc, exp_cyc);
        chk({tag, ".pulse_cnt"}, npulse, int'(h >= 0));
        if (h >= 0) begin
            m_lives--;
            m_hit = h;
            if (m_lives == 0) begin
                m_state = S_OVER;
            end else begin
`ifdef CRASH_GRACE_EN
                m_state = S_GRACE;
                m_cnt   = GF;
`endif
            end
        end else if (m_state == S_GRACE) begin
            m_cnt--;
            if (m_cnt == 0) m_state = S_PLAY;
        end
        chk({tag, ".busy_end"}, int'(bus.scan_busy), 0);
        check_status(tag);
    endtask

    task automatic press_start(input string tag);
        bus.start = 1'b0;
        @(negedge clk);
        if (m_state == S_IDLE || m_state == S_OVER) begin
            m_state = S_PLAY;
            m_lives = LV;
        end
        check_status(tag);
        bus.start = 1'b1;
        @(negedge clk);
    endtask

    task automatic grace_out();
        int guard;
        guard = 0;
        clear_objs();
        while (m_state == S_GRACE && guard < GF + 2) begin
            do_frame("grace_tick");
            guard++;
        end
    endtask

    initial begin
        int np;
        rst_n = 1'b0;
        bus.start = 1'b1;
        bus.frame_tick = 1'b0;
        px = 0;
        py = 0;
        clear_objs();
        drive_bus();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_status("reset");
        chk("reset.pulse", int'(bus.crash_pulse), 0);
        chk("reset.busy", int'(bus.scan_busy), 0);

        // Ticks before start never scan.
        do_frame("idle_tick");
        press_start("start1");

        px = 400; py = 300;
        clear_objs();
        set_obj(1, 460, 350, 1'b1);
        do_frame("first_hit");
        grace_out();

        px = 10; py = 300;
        clear_objs();
        set_obj(0, 4090, 300, 1'b1);
        do_frame("wrap_miss");
        set_obj(0, 0, 300, 1'b1);
        do_frame("wrap_hit");
        grace_out();

        px = 1000; py = 1000;
        clear_objs();
        set_obj(0, 1071, 1000, 1'b1);
        do_frame("dx71_miss");
        set_obj(0, 1000, 1090, 1'b1);
        set_obj(1, 929, 1000, 1'b1);
        do_frame("dy90_miss");
        set_obj(2, 930, 911, 1'b1);
        do_frame("edge_hit");
        do_frame("over_tick1");
        do_frame("over_tick2");
        press_start("restart");
        press_start("start_in_play");

        // Repeated ticks while busy must not restart the scan.
        clear_objs();
        drive_bus();
        bus.frame_tick = 1'b1;
        np = 0;
        for (int c = 1; c <= N + 2; c++) begin
            @(negedge clk);
            if (c >= 3) bus.frame_tick = 1'b0;
            if (bus.crash_pulse) np++;
            if (c == N)     chk("rep.busy_last", int'(bus.scan_busy), 1);
            if (c == N + 1) chk("rep.busy_low", int'(bus.scan_busy), 0);
            if (c == N + 2) chk("rep.busy_stay", int'(bus.scan_busy), 0);
        end
        chk("rep.pulses", np, 0);

        for (int i = 0; i < 150; i++) begin
            px = $urandom_range(4095);
            py = $urandom_range(4095);
            for (int k = 0; k < N; k++) begin
                set_obj(k, (px + $urandom_range(220) - 110) & 12'hFFF,
                           (py + $urandom_range(260) - 130) & 12'hFFF,
                           1'($urandom_range(1)));
            end
            if ($urandom_range(9) == 0) press_start("rnd_start");
            do_frame("rnd");
        end

        if (m_state == S_IDLE || m_state == S_OVER) press_start("pre_rst");
        grace_out();

        // Reset in the middle of a scan that would hit on slot 2.
        px = 500; py = 500;
        clear_objs();
        set_obj(2, 520, 520, 1'b1);
        drive_bus();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_status("rst_scan");
        chk("rst_scan.busy", int'(bus.scan_busy), 0);
        np = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.crash_pulse) np++;
        end
        chk("rst_scan.pulses", np, 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef CRASH_GRACE_EN
        press_start("start_g");
        px = 500; py = 500;
        clear_objs();
        set_obj(0, 500, 500, 1'b1);
        do_frame("grace_hit");
        clear_objs();
        do_frame("grace_cnt1");
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_status("rst_grace");
        chk("rst_grace.pulse", int'(bus.crash_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_status("post_rst");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
